// File: rtl/reservation_station_param_pkg.sv
// rs_pkg: shared definitions for the reservation station slice.
//   OPC_RTYPE / OPC_BRANCH : opcodes whose second ALU operand is rs2, not the immediate
//   rs_entry_t             : per-entry control state (occupancy, operand wait bits, opcode)
//   uses_r2()              : operand-2 source select for a given opcode
package rs_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic       busy;
        logic       wait1;
        logic       wait2;
        logic [6:0] opc;
        logic [3:0] op;
    } rs_entry_t;

    function automatic logic uses_r2(input logic [6:0] opc);
        return (opc == OPC_RTYPE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/reservation_station_param_if.sv
// Dispatch, wakeup and ALU-issue bundle of the reservation station.
//   slave  : the station itself (i_* inputs, o_* outputs)
//   master : the surrounding pipeline (fetcher, wakeup sources, ALU)
interface reservation_station_param_if #(
    parameter int DEPTH    = 16,
    parameter int ROB_W    = 5,
    parameter int XLEN     = 32,
    parameter int NUM_WAKE = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // dispatch
    logic                      i_rs_ready;
    logic [6:0]                i_rs_type;
    logic [3:0]                i_rs_op;
    logic [ROB_W-1:0]          i_rs_rob_id;
    logic [XLEN-1:0]           i_rs_r1;
    logic [XLEN-1:0]           i_rs_r2;
    logic [XLEN-1:0]           i_rs_imm;
    logic                      i_rs_has_dep1;
    logic                      i_rs_has_dep2;
    logic [ROB_W-1:0]          i_rs_dep1;
    logic [ROB_W-1:0]          i_rs_dep2;
    logic                      o_rs_full;
    logic [CNT_W-1:0]          o_rs_count;
    // wakeup broadcast, packed port-major
    logic [NUM_WAKE-1:0]       i_wk_valid;
    logic [NUM_WAKE*ROB_W-1:0] i_wk_tag;
    logic [NUM_WAKE*XLEN-1:0]  i_wk_value;
    // ALU issue
    logic                      i_alu_full;
    logic                      o_alu_ready;
    logic [ROB_W-1:0]          o_alu_rob_id;
    logic [6:0]                o_alu_type;
    logic [3:0]                o_alu_op;
    logic [XLEN-1:0]           o_alu_v1;
    logic [XLEN-1:0]           o_alu_v2;

    modport slave (
        input  i_rs_ready, i_rs_type, i_rs_op, i_rs_rob_id, i_rs_r1, i_rs_r2, i_rs_imm,
               i_rs_has_dep1, i_rs_has_dep2, i_rs_dep1, i_rs_dep2,
               i_wk_valid, i_wk_tag, i_wk_value, i_alu_full,
        output o_rs_full, o_rs_count, o_alu_ready, o_alu_rob_id, o_alu_type, o_alu_op,
               o_alu_v1, o_alu_v2
    );

    modport master (
        output i_rs_ready, i_rs_type, i_rs_op, i_rs_rob_id, i_rs_r1, i_rs_r2, i_rs_imm,
               i_rs_has_dep1, i_rs_has_dep2, i_rs_dep1, i_rs_dep2,
               i_wk_valid, i_wk_tag, i_wk_value, i_alu_full,
        input  o_rs_full, o_rs_count, o_alu_ready, o_alu_rob_id, o_alu_type, o_alu_op,
               o_alu_v1, o_alu_v2
    );

endinterface

// File: rtl/reservation_station_param_age_picker.sv
// rs_age_picker: oldest-ready selection from an age matrix.
//   i_ready : per-entry ready vector
//   i_older : i_older[i][j] = 1 when entry j is older than entry i
//   o_grant : one-hot grant of the ready entry with no older ready entry
//   o_valid : some entry is granted
//   o_idx   : binary index of the granted entry
module rs_age_picker #(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0]            i_ready,
    input  logic [DEPTH-1:0][DEPTH-1:0] i_older,
    output logic [DEPTH-1:0]            o_grant,
    output logic                        o_valid,
    output logic [$clog2(DEPTH)-1:0]    o_idx
);
    localparam int IDX_W = $clog2(DEPTH);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_grant[i] = i_ready[i] && !(|(i_ready & i_older[i]));
        end
        // The matrix is a strict order over busy entries, so the grant is one-hot
        // and OR-ing the indices yields the binary index directly.
        for (int i = 0; i < DEPTH; i++) begin
            if (o_grant[i]) o_idx = o_idx | IDX_W'(i);
        end
        o_valid = |o_grant;
    end

endmodule

// File: rtl/reservation_station_param.sv
// reservation_station_param: DEPTH-entry reservation station between dispatch and the ALU.
//   clk_in  : clock
//   rst_in  : asynchronous active-low reset
//   rdy_in  : global enable, low freezes all state and suppresses issue
//   i_clear : synchronous flush on mispredict
//   bus     : dispatch / wakeup / ALU bundle (slave side)
// Entries wait for operands, snoop NUM_WAKE broadcast ports, and the oldest ready entry is
// presented to the ALU each cycle; it is popped when the ALU is not full.
module reservation_station_param
    import rs_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int ROB_W    = 5,
    parameter int XLEN     = 32,
    parameter int NUM_WAKE = 5
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic i_clear,
    reservation_station_param_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    rs_entry_t                   r_ent   [DEPTH];
    logic [ROB_W-1:0]            r_rob   [DEPTH];
    logic [ROB_W-1:0]            r_tag1  [DEPTH];
    logic [ROB_W-1:0]            r_tag2  [DEPTH];
    logic [XLEN-1:0]             r_v1    [DEPTH];
    logic [XLEN-1:0]             r_v2    [DEPTH];
    logic [XLEN-1:0]             r_imm   [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] r_older;
    logic [CNT_W-1:0]            r_count;

    logic [DEPTH-1:0]            w_busy, w_ready, w_grant, w_pop_vec, w_ins_vec;
    logic [DEPTH-1:0]            w_hit1, w_hit2;
    logic [XLEN-1:0]             w_val1  [DEPTH];
    logic [XLEN-1:0]             w_val2  [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] w_older_nxt;
    logic                        w_gnt_vld, w_free_vld, w_ins, w_pop;
    logic                        w_in_hit1, w_in_hit2;
    logic [XLEN-1:0]             w_in_val1, w_in_val2;
    logic [IDX_W-1:0]            w_gnt_idx, w_free_idx;

    // Returns {hit, value}; later ports overwrite earlier ones so the highest index wins.
    function automatic logic [XLEN:0] wake_lookup(
        input logic [ROB_W-1:0]          tag,
        input logic [NUM_WAKE-1:0]       vld,
        input logic [NUM_WAKE*ROB_W-1:0] tags,
        input logic [NUM_WAKE*XLEN-1:0]  vals
    );
        logic [XLEN:0] res;
        res = '0;
        for (int p = 0; p < NUM_WAKE; p++) begin
            if (vld[p] && (tags[p*ROB_W +: ROB_W] == tag)) res = {1'b1, vals[p*XLEN +: XLEN]};
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_busy[i]  = r_ent[i].busy;
            w_ready[i] = r_ent[i].busy && !r_ent[i].wait1 && !r_ent[i].wait2;
            {w_hit1[i], w_val1[i]} = wake_lookup(r_tag1[i], bus.i_wk_valid, bus.i_wk_tag, bus.i_wk_value);
            {w_hit2[i], w_val2[i]} = wake_lookup(r_tag2[i], bus.i_wk_valid, bus.i_wk_tag, bus.i_wk_value);
        end
        {w_in_hit1, w_in_val1} = wake_lookup(bus.i_rs_dep1, bus.i_wk_valid, bus.i_wk_tag, bus.i_wk_value);
        {w_in_hit2, w_in_val2} = wake_lookup(bus.i_rs_dep2, bus.i_wk_valid, bus.i_wk_tag, bus.i_wk_value);
    end

    // Lowest free index: scan downward so the smallest index is written last.
    always_comb begin
        w_free_vld = 1'b0;
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!w_busy[i]) begin
                w_free_vld = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    rs_age_picker #(.DEPTH(DEPTH)) u_picker (
        .i_ready (w_ready),
        .i_older (r_older),
        .o_grant (w_grant),
        .o_valid (w_gnt_vld),
        .o_idx   (w_gnt_idx)
    );

    // Fullness comes from the registered count, so a pop does not open a slot the same cycle.
    assign bus.o_rs_count = r_count;
    assign bus.o_rs_full  = (r_count == CNT_W'(DEPTH));
    assign w_ins          = rdy_in && bus.i_rs_ready && !bus.o_rs_full && w_free_vld;
    assign w_pop          = bus.o_alu_ready && !bus.i_alu_full;
    assign w_pop_vec      = w_pop ? w_grant : '0;
    assign w_ins_vec      = w_ins ? (DEPTH'(1) << w_free_idx) : '0;

    // Issue fields are zeroed when nothing is selected so unreset payload never leaks out.
    always_comb begin
        bus.o_alu_ready  = rdy_in && w_gnt_vld;
        bus.o_alu_rob_id = '0;
        bus.o_alu_type   = '0;
        bus.o_alu_op     = '0;
        bus.o_alu_v1     = '0;
        bus.o_alu_v2     = '0;
        if (w_gnt_vld) begin
            bus.o_alu_rob_id = r_rob[w_gnt_idx];
            bus.o_alu_type   = r_ent[w_gnt_idx].opc;
            bus.o_alu_op     = r_ent[w_gnt_idx].op;
            bus.o_alu_v1     = r_v1[w_gnt_idx];
            bus.o_alu_v2     = uses_r2(r_ent[w_gnt_idx].opc) ? r_v2[w_gnt_idx] : r_imm[w_gnt_idx];
        end
    end

    // Age update: a new entry is younger than every survivor; popped entries leave the order.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                w_older_nxt[i][j] = r_older[i][j] && !w_pop_vec[i] && !w_pop_vec[j];
                if (w_ins_vec[i]) w_older_nxt[i][j] = w_busy[j] && !w_pop_vec[j];
                if (w_ins_vec[j]) w_older_nxt[i][j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_older <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            if (i_clear) begin
                for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
                r_older <= '0;
                r_count <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_pop_vec[i]) begin
                        r_ent[i].busy <= 1'b0;
                    end else if (r_ent[i].busy) begin
                        if (r_ent[i].wait1 && w_hit1[i]) r_ent[i].wait1 <= 1'b0;
                        if (r_ent[i].wait2 && w_hit2[i]) r_ent[i].wait2 <= 1'b0;
                    end
                end
                if (w_ins) begin
                    r_ent[w_free_idx] <= '{busy:  1'b1,
                                           wait1: bus.i_rs_has_dep1 && !w_in_hit1,
                                           wait2: bus.i_rs_has_dep2 && !w_in_hit2,
                                           opc:   bus.i_rs_type,
                                           op:    bus.i_rs_op};
                end
                r_older <= w_older_nxt;
                if (w_ins && !w_pop)      r_count <= r_count + CNT_W'(1);
                else if (!w_ins && w_pop) r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Payload is only meaningful while its entry is busy, so it carries no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !i_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_ent[i].busy && r_ent[i].wait1 && w_hit1[i]) r_v1[i] <= w_val1[i];
                if (r_ent[i].busy && r_ent[i].wait2 && w_hit2[i]) r_v2[i] <= w_val2[i];
            end
            if (w_ins) begin
                r_rob[w_free_idx]  <= bus.i_rs_rob_id;
                r_tag1[w_free_idx] <= bus.i_rs_dep1;
                r_tag2[w_free_idx] <= bus.i_rs_dep2;
                r_imm[w_free_idx]  <= bus.i_rs_imm;
                r_v1[w_free_idx]   <= (bus.i_rs_has_dep1 && w_in_hit1) ? w_in_val1 : bus.i_rs_r1;
                r_v2[w_free_idx]   <= (bus.i_rs_has_dep2 && w_in_hit2) ? w_in_val2 : bus.i_rs_r2;
            end
        end
    end

    a_no_insert_when_full: assert property (@(posedge clk_in) disable iff (!rst_in)
        (rdy_in && !i_clear && bus.i_rs_ready) |-> !bus.o_rs_full)
        else $warning("dispatch while station full; instruction dropped");

endmodule
